// File: rtl/alu_writeback_if.sv
// ALU-to-writeback handshake bundle: one op per valid/ready transfer.
interface alu_writeback_if #(
  parameter int unsigned NREGS = 4,
  parameter int unsigned DW    = 8
);
  localparam int unsigned AW = $clog2(NREGS);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_result;
  logic          in_cout;
  logic          in_zout;
  logic          in_we;
  logic [AW-1:0] in_dest;
  logic          in_setf;

  modport master (
    output in_valid, in_result, in_cout, in_zout, in_we, in_dest, in_setf,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_result, in_cout, in_zout, in_we, in_dest, in_setf,
    output in_ready
  );
endinterface

// File: rtl/alu_writeback.sv
// Writeback stage after the 8-bit ALU: one-entry pipeline register,
// NREGS x DW register file, C/Z flag register and two combinational
// operand read ports.
// Optional feature macro: ALU_WB_BYPASS_EN forwards a pending write to the
// read ports; undefined, reads return committed register contents only.
module alu_writeback #(
  parameter  int unsigned NREGS = 4,
  parameter  int unsigned DW    = 8,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_writeback_if.slave      wb,
  input  logic                stall,
  input  logic [AW-1:0]       ra_addr,
  input  logic [AW-1:0]       rb_addr,
  output logic [DW-1:0]       ra_data,
  output logic [DW-1:0]       rb_data,
  output logic                c_flag,
  output logic                z_flag,
  output logic                busy
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t        state_q, state_d;
  logic          p_valid;
  logic [DW-1:0] p_result;
  logic          p_cout;
  logic          p_zout;
  logic          p_we;
  logic [AW-1:0] p_dest;
  logic          p_setf;
  logic          accept;
  logic          commit;
  logic [DW-1:0] regs [NREGS];

  assign p_valid     = (state_q == FULL);
  assign commit      = p_valid & ~stall;
  assign wb.in_ready = ~p_valid | commit;
  assign accept      = wb.in_valid & wb.in_ready;
  assign busy        = p_valid;

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next occupancy: a fresh accept keeps or makes the stage full.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (commit && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Pipeline data fields load only on accept and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_result <= '0;
      p_cout   <= 1'b0;
      p_zout   <= 1'b0;
      p_we     <= 1'b0;
      p_dest   <= '0;
      p_setf   <= 1'b0;
    end else if (accept) begin
      p_result <= wb.in_result;
      p_cout   <= wb.in_cout;
      p_zout   <= wb.in_zout;
      p_we     <= wb.in_we;
      p_dest   <= wb.in_dest;
      p_setf   <= wb.in_setf;
    end
  end

  // Register file write on commit of an op with we set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (commit && p_we) begin
      regs[p_dest] <= p_result;
    end
  end

  // Flag register update on commit of an op with setf set, independent of we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_flag <= 1'b0;
      z_flag <= 1'b0;
    end else if (commit && p_setf) begin
      c_flag <= p_cout;
      z_flag <= p_zout;
    end
  end

  // Operand read ports, optionally forwarding the pending write.
  always_comb begin
    ra_data = regs[ra_addr];
    rb_data = regs[rb_addr];
`ifdef ALU_WB_BYPASS_EN
    if (p_valid && p_we && (p_dest == ra_addr)) ra_data = p_result;
    if (p_valid && p_we && (p_dest == rb_addr)) rb_data = p_result;
`endif
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: scoreboard queue of accepted ops,
// popped at commit into a reference register file and flag model.
module tb_alu_writeback;

  logic       clk;
  logic       rst_n;
  logic       stall;
  logic [1:0] ra_addr, rb_addr;
  logic [7:0] ra_data, rb_data;
  logic       c_flag, z_flag, busy;

  alu_writeback_if #(.NREGS(4), .DW(8)) wb_if ();

  alu_writeback #(.NREGS(4), .DW(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wb      (wb_if),
    .stall   (stall),
    .ra_addr (ra_addr),
    .rb_addr (rb_addr),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .c_flag  (c_flag),
    .z_flag  (z_flag),
    .busy    (busy)
  );

  typedef struct {
    logic       we;
    logic [1:0] dest;
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       setf;
  } ent_t;

  ent_t       sb[$];
  logic [7:0] mregs [4];
  logic       mc, mz;
  int         total = 0;
  int         bad   = 0;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_rd(input int a);
    logic [7:0] v;
    v = mregs[a];
`ifdef ALU_WB_BYPASS_EN
    if (sb.size() != 0 && sb[0].we && sb[0].dest == 2'(a)) v = sb[0].res;
`endif
    return v;
  endfunction

  task automatic model_reset();
    sb.delete();
    for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
    mc = 1'b0;
    mz = 1'b0;
  endtask

  task automatic check_state();
    check("busy", 32'(busy), 32'(sb.size() != 0));
    check("c_flag", 32'(c_flag), 32'(mc));
    check("z_flag", 32'(z_flag), 32'(mz));
    for (int i = 0; i < 4; i++) begin
      ra_addr = 2'(i);
      rb_addr = 2'(3 - i);
      #1;
      check($sformatf("ra_data[%0d]", i), 32'(ra_data), 32'(exp_rd(i)));
      check($sformatf("rb_data[%0d]", 3 - i), 32'(rb_data), 32'(exp_rd(3 - i)));
    end
  endtask

  task automatic op(input logic we, input logic [1:0] dest, input logic [7:0] res,
                    input logic c, input logic z, input logic setf);
    wb_if.in_valid  = 1'b1;
    wb_if.in_we     = we;
    wb_if.in_dest   = dest;
    wb_if.in_result = res;
    wb_if.in_cout   = c;
    wb_if.in_zout   = z;
    wb_if.in_setf   = setf;
  endtask

  // One clock: check ready against the model, then advance the model at the edge.
  task automatic tick();
    logic m_commit, m_ready, m_acc;
    ent_t e, n;
    #1;
    m_commit = (sb.size() != 0) && !stall;
    m_ready  = (sb.size() == 0) || m_commit;
    m_acc    = wb_if.in_valid && m_ready;
    check("in_ready", 32'(wb_if.in_ready), 32'(m_ready));
    n.we = wb_if.in_we; n.dest = wb_if.in_dest; n.res = wb_if.in_result;
    n.c = wb_if.in_cout; n.z = wb_if.in_zout; n.setf = wb_if.in_setf;
    @(posedge clk);
    if (m_commit) begin
      e = sb.pop_front();
      if (e.we) mregs[e.dest] = e.res;
      if (e.setf) begin
        mc = e.c;
        mz = e.z;
      end
    end
    if (m_acc) sb.push_back(n);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    ra_addr = '0;
    rb_addr = '0;
    wb_if.in_valid = 1'b0;
    op(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    wb_if.in_valid = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_ready", 32'(wb_if.in_ready), 32'd1);
    check_state();

    // Single op
    op(1'b1, 2'd2, 8'h3C, 1'b1, 1'b0, 1'b1);
    tick();
    wb_if.in_valid = 1'b0;
    check_state();
    tick();
    check_state();

    // Back-to-back, no stall
    for (int i = 0; i < 4; i++) begin
      op(1'b1, 2'(i), 8'(8'h11 * (i + 1)), 1'b0, 1'b0, 1'b0);
      tick();
      check_state();
    end
    wb_if.in_valid = 1'b0;
    tick();
    check_state();

    // Stall holds entry; competing op is ignored
    op(1'b1, 2'd1, 8'h55, 1'b0, 1'b0, 1'b0);
    tick();
    stall = 1'b1;
    op(1'b1, 2'd0, 8'h99, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_state();
    end
    wb_if.in_valid = 1'b0;
    stall = 1'b0;
    tick();
    check_state();

    // Flags only
    op(1'b0, 2'd0, 8'hFF, 1'b0, 1'b1, 1'b1);
    tick();
    wb_if.in_valid = 1'b0;
    tick();
    check_state();

    // Random traffic with random stalls
    for (int i = 0; i < 40; i++) begin
      op(1'($urandom), 2'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      wb_if.in_valid = 1'($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 3) == 0);
      tick();
      check_state();
    end
    wb_if.in_valid = 1'b0;
    stall = 1'b0;
    tick();
    check_state();

    // Pending write to r3 visible (or not) on read port, then reset mid-pending
    op(1'b1, 2'd3, 8'hA5, 1'b1, 1'b1, 1'b1);
    tick();
    wb_if.in_valid = 1'b0;
    stall = 1'b1;
    check_state();
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_state();
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    check_state();
    tick();
    check_state();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
